// File: rtl/elevator_ctrl_n_pkg.sv
// Shared definitions for the N-floor elevator controller: state encodings,
// a width helper and the direction-aware "calls ahead" reduction.
package elevator_ctrl_n_pkg;

  localparam int MAX_FLOORS = 16;

  typedef enum logic [1:0] {
    ST_CLOSED = 2'd0,
    ST_OPEN   = 2'd1,
    ST_MOVING = 2'd2
  } state_e;

  // Bits needed to index n items, never less than one.
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // True when any pending call lies strictly above (up=1) or below (up=0) floor f.
  function automatic logic any_ahead(input logic [MAX_FLOORS-1:0] p,
                                     input logic [3:0]            f,
                                     input logic                  up);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      if (p[i] && (up ? (4'(i) > f) : (4'(i) < f))) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/elevator_ctrl_n_timer.sv
// Loadable down-counter shared by door and travel timing; it holds at zero.
module elevator_ctrl_n_timer #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] count_q, count_d;

  // Load takes priority over counting down; the count saturates at zero.
  always_comb begin
    count_d = count_q;
    if (load_i)                        count_d = value_i;
    else if (en_i && count_q != '0)    count_d = count_q - W'(1);
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/elevator_ctrl_n.sv
// N-floor SCAN elevator controller with latched calls, door hold and timed travel.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_CLOSED | stopped at a floor, door shut, choosing what to do next
//   ST_OPEN   | stopped at a floor, door open, door timer running
//   ST_MOVING | travelling from floor_q one step in dir_q, travel timer running
module elevator_ctrl_n
  import elevator_ctrl_n_pkg::*;
#(
  parameter int NUM_FLOORS    = 3,
  parameter int TRAVEL_CYCLES = 2,
  parameter int DOOR_CYCLES   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_FLOORS-1:0] flr_req_i,
  input  logic                  door_block_i,
  output logic [NUM_FLOORS-1:0] at_flr_o,
  output logic                  door_open_o,
  output logic                  moving_o,
  output logic                  dir_up_o,
  output logic [NUM_FLOORS-1:0] pending_o
);

  localparam int FW   = width_of(NUM_FLOORS);
  localparam int TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW   = width_of(TMAX);

  localparam logic [FW-1:0] TOP_FLOOR   = FW'(NUM_FLOORS - 1);
  localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_CYCLES - 1);

  state_e                state_q, state_d;
  logic [FW-1:0]         floor_q, floor_d;
  logic                  dir_q, dir_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;

  logic          tmr_load, tmr_en, tmr_zero;
  logic [TW-1:0] tmr_val;

  logic [FW-1:0] next_floor;
  logic          ahead_cur, behind_cur, ahead_next;
  logic          here_call, arrive_hit, depart_up;

  elevator_ctrl_n_timer #(.W(TW)) u_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (tmr_load),
    .value_i (tmr_val),
    .en_i    (tmr_en),
    .zero_o  (tmr_zero)
  );

  assign next_floor = dir_q ? (floor_q + FW'(1)) : (floor_q - FW'(1));
  assign ahead_cur  = any_ahead(16'(pending_q), 4'(floor_q), dir_q);
  assign behind_cur = any_ahead(16'(pending_q), 4'(floor_q), ~dir_q);
  assign ahead_next = any_ahead(16'(pending_q), 4'(next_floor), dir_q);
  assign here_call  = door_block_i | flr_req_i[floor_q];
  // A call for the arrival floor raised on the arrival edge itself is served
  // too, so the bit can never be left stranded at a floor the car stops at.
  assign arrive_hit = pending_q[next_floor] | flr_req_i[next_floor];

  // Departure direction: keep going if calls are ahead, otherwise reverse;
  // the end floors pin the direction so the car cannot run off either end.
  always_comb begin
    depart_up = ahead_cur ? dir_q : ~dir_q;
    if (floor_q == '0)             depart_up = 1'b1;
    else if (floor_q == TOP_FLOOR) depart_up = 1'b0;
  end

  // Next-state, request latching and timer control.
  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    dir_d     = dir_q;
    pending_d = pending_q | flr_req_i;
    tmr_load  = 1'b0;
    tmr_val   = DOOR_LOAD;
    tmr_en    = 1'b0;
    case (state_q)
      ST_CLOSED: begin
        pending_d[floor_q] = pending_q[floor_q];
        if (here_call) begin
          state_d  = ST_OPEN;
          tmr_load = 1'b1;
          tmr_val  = DOOR_LOAD;
        end else if (ahead_cur || behind_cur) begin
          state_d  = ST_MOVING;
          dir_d    = depart_up;
          tmr_load = 1'b1;
          tmr_val  = TRAVEL_LOAD;
        end
      end
      ST_OPEN: begin
        pending_d[floor_q] = pending_q[floor_q];
        if (here_call) begin
          tmr_load = 1'b1;
          tmr_val  = DOOR_LOAD;
        end else if (tmr_zero) begin
          state_d = ST_CLOSED;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_MOVING: begin
        if (!tmr_zero) begin
          tmr_en = 1'b1;
        end else begin
          floor_d = next_floor;
          if (arrive_hit) begin
            state_d               = ST_OPEN;
            pending_d[next_floor] = 1'b0;
            tmr_load              = 1'b1;
            tmr_val               = DOOR_LOAD;
          end else if (ahead_next) begin
            tmr_load = 1'b1;
            tmr_val  = TRAVEL_LOAD;
          end else begin
            state_d = ST_CLOSED;
          end
        end
      end
      default: state_d = ST_CLOSED;
    endcase
  end

  // State registers with synchronous reset to floor 0, door shut, heading up.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_CLOSED;
      floor_q   <= '0;
      dir_q     <= 1'b1;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      dir_q     <= dir_d;
      pending_q <= pending_d;
    end
  end

  // One-hot floor LEDs decoded from the registered floor index.
  always_comb begin
    at_flr_o = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      at_flr_o[i] = (floor_q == FW'(i));
    end
  end

  assign door_open_o = (state_q == ST_OPEN);
  assign moving_o    = (state_q == ST_MOVING);
  assign dir_up_o    = dir_q;
  assign pending_o   = pending_q;

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Bench for elevator_ctrl_n: directed scenarios with literal expectations plus
// a randomized run, all compared every cycle against a behavioural model.
module tb_elevator_ctrl_n;

  localparam int N = 4;
  localparam int T = 2;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] flr_req = '0;
  logic         door_block = 1'b0;
  logic [N-1:0] at_flr, pending;
  logic         door_open, moving, dir_up;

  elevator_ctrl_n #(.NUM_FLOORS(N), .TRAVEL_CYCLES(T), .DOOR_CYCLES(D)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flr_req_i    (flr_req),
    .door_block_i (door_block),
    .at_flr_o     (at_flr),
    .door_open_o  (door_open),
    .moving_o     (moving),
    .dir_up_o     (dir_up),
    .pending_o    (pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int stray  = 0;
  int cyc    = 0;

  // Behavioural model: car position, door/motion flags, cycles left in the
  // current door or travel interval, and the set of waiting calls.
  int           m_floor = 0;
  bit           m_door = 0, m_mov = 0, m_up = 1, m_valid = 0;
  bit [N-1:0]   m_pend = '0;
  int           m_left = 0;

  function automatic bit calls_dir(input bit [N-1:0] p, input int f, input bit up);
    for (int j = 0; j < N; j++) if (p[j] && (up ? (j > f) : (j < f))) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [N-1:0] onehot(input int f);
    logic [N-1:0] v;
    v = '0;
    v[f] = 1'b1;
    return v;
  endfunction

  always @(posedge clk) begin
    bit [N-1:0] req, oldp, newp;
    bit blk;
    int nf;
    req  = flr_req;
    blk  = door_block;
    oldp = m_pend;
    cyc++;
    if (rst === 1'b1) begin
      m_valid = 1; m_floor = 0; m_door = 0; m_mov = 0; m_up = 1; m_pend = '0; m_left = 0;
    end else if (m_valid) begin
      newp = oldp | req;
      if (!m_mov) newp[m_floor] = oldp[m_floor];
      if (!m_mov && !m_door) begin
        if (blk || req[m_floor]) begin
          m_door = 1; m_left = D;
        end else if (calls_dir(oldp, m_floor, m_up)) begin
          m_mov = 1; m_left = T;
        end else if (calls_dir(oldp, m_floor, !m_up)) begin
          m_up = !m_up; m_mov = 1; m_left = T;
        end
      end else if (m_door) begin
        if (blk || req[m_floor]) m_left = D;
        else begin
          m_left--;
          if (m_left == 0) m_door = 0;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          nf = m_up ? m_floor + 1 : m_floor - 1;
          m_floor = nf;
          if (oldp[nf] || req[nf]) begin
            m_mov = 0; m_door = 1; m_left = D; newp[nf] = 1'b0;
          end else if (calls_dir(oldp, nf, m_up)) begin
            m_left = T;
          end else begin
            m_mov = 0;
          end
        end
      end
      m_pend = newp;
    end
  end

  // Advance one cycle and compare all outputs with the model.
  task automatic tick();
    logic [2*N+2:0] exp_v, act_v;
    @(negedge clk);
    if (m_valid) begin
      exp_v = {onehot(m_floor), m_door, m_mov, m_up, m_pend};
      act_v = {at_flr, door_open, moving, dir_up, pending};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL model cyc=%0d got {at,door,mov,dir,pend}=%b required %b", cyc, act_v, exp_v);
      end
      checks++;
      if (door_open && moving) begin
        errors++;
        $display("FAIL exclusive cyc=%0d door_open=%b moving=%b required not both 1", cyc, door_open, moving);
      end
    end
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s cyc=%0d got %h required %h", name, cyc, act, exp_v);
    end
  endtask

  task automatic pulse(input logic [N-1:0] r);
    tick();
    flr_req = r;
    tick();
    flr_req = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; flr_req = '0; door_block = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_state(input logic [N-1:0] want_at, input bit want_door,
                            input int budget, input string name);
    int n;
    n = 0;
    while (!(at_flr === want_at && door_open === want_door) && n < budget) begin
      tick();
      n++;
      if (door_open && at_flr !== want_at) stray++;
    end
    checks++;
    if (!(at_flr === want_at && door_open === want_door)) begin
      errors++;
      $display("FAIL %s timeout got at_flr=%b door=%b required %b/%b", name, at_flr, door_open, want_at, want_door);
    end
  endtask

  logic [3:0] ea [9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b1000};
  logic       ed [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic       em [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [3:0] ep [9] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};

  initial begin
    // Reset then idle: nothing may change.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      lit("idle", {at_flr, door_open, moving, dir_up, pending}, {4'b0001, 1'b0, 1'b0, 1'b1, 4'b0000});
    end

    // Call floor 3 from floor 0: two cycles per floor, no stops at 1 or 2.
    pulse(4'b1000);
    lit("A_latch", {at_flr, moving, pending}, {4'b0001, 1'b0, 4'b1000});
    for (int k = 0; k < 9; k++) begin
      tick();
      lit($sformatf("A_at_%0d", k + 1), at_flr, ea[k]);
      lit($sformatf("A_door_%0d", k + 1), door_open, ed[k]);
      lit($sformatf("A_mov_%0d", k + 1), moving, em[k]);
      lit($sformatf("A_pend_%0d", k + 1), pending, ep[k]);
    end
    lit("A_dir", dir_up, 1);

    // At floor 2 going up, call floors 0 and 3: serve 3, reverse, run to 0.
    do_reset();
    pulse(4'b1000);
    for (int k = 0; k < 5; k++) tick();
    lit("B_at2", {at_flr, moving, dir_up}, {4'b0100, 1'b1, 1'b1});
    flr_req = 4'b1001;
    tick();
    flr_req = '0;
    lit("B_pend", pending, 4'b1001);
    wait_state(4'b1000, 1'b1, 10, "B_open3");
    lit("B_pend3", pending, 4'b0001);
    wait_state(4'b1000, 1'b0, 10, "B_close3");
    stray = 0;
    wait_state(4'b0001, 1'b1, 30, "B_open0");
    lit("B_stray", stray, 0);
    lit("B_dir", dir_up, 0);
    lit("B_pend0", pending, 4'b0000);

    // Door held at floor 1 with a call for floor 3 waiting.
    do_reset();
    pulse(4'b0010);
    wait_state(4'b0010, 1'b1, 20, "C_open1");
    door_block = 1'b1;
    flr_req = 4'b1000;
    tick();
    flr_req = '0;
    lit("C_hold_0", {door_open, moving, pending}, {1'b1, 1'b0, 4'b1000});
    for (int i = 1; i < 5; i++) begin
      tick();
      lit($sformatf("C_hold_%0d", i), {door_open, moving, pending}, {1'b1, 1'b0, 4'b1000});
    end
    door_block = 1'b0;
    tick();
    lit("C_after1", {door_open, moving}, {1'b1, 1'b0});
    tick();
    lit("C_closed", {door_open, moving, pending}, {1'b0, 1'b0, 4'b1000});
    tick();
    lit("C_depart", {door_open, moving, at_flr}, {1'b0, 1'b1, 4'b0010});

    // Current-floor call while closed at floor 2.
    do_reset();
    pulse(4'b0100);
    wait_state(4'b0100, 1'b1, 20, "D_open2");
    wait_state(4'b0100, 1'b0, 10, "D_close2");
    flr_req = 4'b0100;
    tick();
    flr_req = '0;
    lit("D_open", {door_open, pending}, {1'b1, 4'b0000});
    tick();
    lit("D_pend", {door_open, pending}, {1'b1, 4'b0000});

    // Reset between floors 1 and 2.
    do_reset();
    pulse(4'b1000);
    wait_state(4'b0010, 1'b0, 10, "E_at1");
    lit("E_moving", moving, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    lit("E_reset", {at_flr, door_open, moving, dir_up, pending}, {4'b0001, 1'b0, 1'b0, 1'b1, 4'b0000});

    // Randomized traffic with occasional blocks and resets.
    for (int i = 0; i < 4000; i++) begin
      tick();
      rst = ($urandom_range(0, 399) == 0);
      for (int b = 0; b < N; b++) flr_req[b] = ($urandom_range(0, 11) == 0);
      door_block = ($urandom_range(0, 9) == 0);
    end
    rst = 1'b0; flr_req = '0; door_block = 1'b0;
    for (int i = 0; i < 40; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
